// File: rtl/pipe_arith_pkg.sv
// Shared types for the pipelined lane-parallel arithmetic array.
//   arith_mode_e    : operation selector carried alongside each beat
//   stage_payload_t : per-stage control payload shared by all lanes
package pipe_arith_pkg;

    typedef enum logic [1:0] {
        ARITH_ADD  = 2'b00,
        ARITH_MUL  = 2'b01,
        ARITH_MAC  = 2'b10,
        ARITH_PASS = 2'b11
    } arith_mode_e;

    typedef struct packed {
        logic        valid;
        arith_mode_e mode;
        logic        clear;
    } stage_payload_t;

endpackage

// File: rtl/pipe_arith_lane.sv
// One lane: raw op in the first stage, raw-result delay registers, and the
// final stage holding the result register and the MAC accumulator.
//   clk_i, reset_i : clock, synchronous active-high reset
//   en_i           : pipeline advance (low while the output is stalled)
//   mode_i, x_i/y_i: operation and operands of the beat entering stage 1
//   fin_*_i        : control of the beat entering the final stage
//   c_o            : lane result
module pipe_arith_lane
    import pipe_arith_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned OutputWidth = 32,
    parameter int unsigned Stages      = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  arith_mode_e            mode_i,
    input  logic [DataWidth-1:0]   x_i,
    input  logic [DataWidth-1:0]   y_i,
    input  logic                   fin_valid_i,
    input  arith_mode_e            fin_mode_i,
    input  logic                   fin_clear_i,
    output logic [OutputWidth-1:0] c_o
);

    // Wide enough for the full product and for zero-extension to OutputWidth.
    localparam int unsigned WideW = 2 * DataWidth + OutputWidth;

    logic [WideW-1:0] x_w, y_w, wide;

    always_comb begin
        x_w = WideW'(x_i);
        y_w = WideW'(y_i);
        case (mode_i)
            ARITH_ADD:           wide = x_w + y_w;
            ARITH_MUL, ARITH_MAC: wide = x_w * y_w;
            default:             wide = x_w;
        endcase
    end

    // raw_pipe[0] is combinational; raw_pipe[k] is the k-th delay register.
    logic [OutputWidth-1:0] raw_pipe [Stages];

    assign raw_pipe[0] = wide[OutputWidth-1:0];

    for (genvar k = 1; k < Stages; k++) begin : g_raw
        vc_ResetEnReg #(.Width(OutputWidth)) u_raw (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en_i    (en_i),
            .d_i     (raw_pipe[k-1]),
            .q_o     (raw_pipe[k])
        );
    end

    logic [OutputWidth-1:0] fin_raw, acc_q, acc_d, c_d;
    logic                   c_en, acc_en, fin_is_mac;

    always_comb begin
        fin_raw    = raw_pipe[Stages-1];
        fin_is_mac = (fin_mode_i == ARITH_MAC);
        acc_d      = (fin_clear_i ? '0 : acc_q) + fin_raw;
        c_d        = fin_is_mac ? acc_d : fin_raw;
        c_en       = en_i & fin_valid_i;
        acc_en     = c_en & fin_is_mac;
    end

    vc_ResetEnReg #(.Width(OutputWidth)) u_acc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (acc_en),
        .d_i     (acc_d),
        .q_o     (acc_q)
    );

    vc_ResetEnReg #(.Width(OutputWidth)) u_c (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (c_en),
        .d_i     (c_d),
        .q_o     (c_o)
    );

endmodule

// File: rtl/vc_ResetEnReg.sv
// Register with synchronous active-high reset and load enable.
//   clk_i   : clock
//   reset_i : synchronous reset, clears q_o to zero
//   en_i    : load enable
//   d_i     : next value
//   q_o     : registered value
module vc_ResetEnReg #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_arith_array.sv
// LANES-wide pipelined unsigned ADD/MUL/MAC/PASS array with valid/ready flow
// control. Owns the shared valid/mode/clear chain and the stall logic.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_mode/in_clear per beat
//   x, y                : packed lane operands
//   out_valid/out_ready : output handshake
//   c                   : packed lane results
module pipe_arith_array
    import pipe_arith_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OUTPUT_WIDTH = 32,
    parameter int unsigned LANES        = 4,
    parameter int unsigned STAGES       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_mode,
    input  logic                          in_clear,
    input  logic [LANES*DATA_WIDTH-1:0]   x,
    input  logic [LANES*DATA_WIDTH-1:0]   y,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*OUTPUT_WIDTH-1:0] c
);

    logic stall, adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    // pay[0] is the incoming beat; pay[k] is the control of pipeline stage k.
    // pay[STAGES-1] is what enters the final (output) stage next.
    stage_payload_t pay [STAGES];

    assign pay[0] = '{valid: in_valid, mode: arith_mode_e'(in_mode), clear: in_clear};

    for (genvar k = 1; k < STAGES; k++) begin : g_pay
        vc_ResetEnReg #(.Width($bits(stage_payload_t))) u_pay (
            .clk_i   (clk),
            .reset_i (reset),
            .en_i    (adv),
            .d_i     (pay[k-1]),
            .q_o     (pay[k])
        );
    end

    vc_ResetEnReg #(.Width(1)) u_out_valid (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (adv),
        .d_i     (pay[STAGES-1].valid),
        .q_o     (out_valid)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pipe_arith_lane #(
            .DataWidth   (DATA_WIDTH),
            .OutputWidth (OUTPUT_WIDTH),
            .Stages      (STAGES)
        ) u_lane (
            .clk_i       (clk),
            .reset_i     (reset),
            .en_i        (adv),
            .mode_i      (pay[0].mode),
            .x_i         (x[i*DATA_WIDTH +: DATA_WIDTH]),
            .y_i         (y[i*DATA_WIDTH +: DATA_WIDTH]),
            .fin_valid_i (pay[STAGES-1].valid),
            .fin_mode_i  (pay[STAGES-1].mode),
            .fin_clear_i (pay[STAGES-1].clear),
            .c_o         (c[i*OUTPUT_WIDTH +: OUTPUT_WIDTH])
        );
    end

endmodule

// File: tb/tb_pipe_arith_array.sv
module tb_pipe_arith_array;
    import pipe_arith_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic         in_clear;
    logic [127:0] x, y;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_arith_array #(
        .DATA_WIDTH   (32),
        .OUTPUT_WIDTH (32),
        .LANES        (4),
        .STAGES       (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_clear  (in_clear),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    typedef struct {
        arith_mode_e mode;
        logic        clear;
        logic [31:0] xv;
        logic [31:0] yv;
        logic [31:0] exp;
    } vec_t;

    localparam int NVec = 15;
    vec_t vecs [NVec];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input arith_mode_e m, input logic clr,
                         input logic [31:0] xv, input logic [31:0] yv);
        in_valid = v;
        in_mode  = m;
        in_clear = clr;
        x        = {4{xv}};
        y        = {4{yv}};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{ARITH_ADD,  1'b0, 32'd5,          32'd7,          32'd12};
        vecs[1]  = '{ARITH_MUL,  1'b0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE};
        vecs[2]  = '{ARITH_ADD,  1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[3]  = '{ARITH_PASS, 1'b0, 32'h0000_1234,  32'd9,          32'h0000_1234};
        vecs[4]  = '{ARITH_MAC,  1'b1, 32'd3,          32'd4,          32'd12};
        vecs[5]  = '{ARITH_MAC,  1'b0, 32'd2,          32'd5,          32'd22};
        vecs[6]  = '{ARITH_MAC,  1'b0, 32'd1,          32'd1,          32'd23};
        vecs[7]  = '{ARITH_ADD,  1'b1, 32'd1,          32'd1,          32'd2};
        vecs[8]  = '{ARITH_MAC,  1'b0, 32'd1,          32'd2,          32'd25};
        vecs[9]  = '{ARITH_MAC,  1'b1, 32'd2,          32'd2,          32'd4};
        vecs[10] = '{ARITH_MUL,  1'b1, 32'd10,         32'd10,         32'd100};
        vecs[11] = '{ARITH_MAC,  1'b0, 32'd0,          32'd0,          32'd4};
        vecs[12] = '{ARITH_MUL,  1'b0, 32'h0001_0000,  32'h0001_0000,  32'd0};
        vecs[13] = '{ARITH_MAC,  1'b0, 32'hFFFF_FFFF,  32'd1,          32'd3};
        vecs[14] = '{ARITH_PASS, 1'b1, 32'hDEAD_BEEF,  32'd0,          32'hDEAD_BEEF};

        // Reset for 3 cycles with the consumer ready.
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, ARITH_ADD, 1'b0, 32'd0, 32'd0);
        repeat (3) tick();
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_c", c, 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        reset = 1'b0;
        tick();
        chk("idle_out_valid", 128'(out_valid), 128'd0);

        // ADD latency: result appears exactly two cycles after acceptance.
        drive(1'b1, ARITH_ADD, 1'b0, 32'd5, 32'd7);
        tick();
        chk("lat_cycle1_valid", 128'(out_valid), 128'd0);
        in_valid = 1'b0;
        tick();
        chk("lat_cycle2_valid", 128'(out_valid), 128'd1);
        chk("lat_cycle2_c", c, {4{32'd12}});
        tick();
        chk("lat_after_valid", 128'(out_valid), 128'd0);
        chk("lat_c_held", c, {4{32'd12}});

        // Back-to-back table stream at full throughput.
        for (int n = 0; n <= NVec; n++) begin
            if (n < NVec) drive(1'b1, vecs[n].mode, vecs[n].clear, vecs[n].xv, vecs[n].yv);
            else in_valid = 1'b0;
            tick();
            if (n == 0) begin
                chk("vec_first_valid", 128'(out_valid), 128'd0);
            end else begin
                chk($sformatf("vec%0d_valid", n - 1), 128'(out_valid), 128'd1);
                chk($sformatf("vec%0d_c", n - 1), c, {4{vecs[n-1].exp}});
            end
        end
        tick();

        // Distinct operands per lane to check lane packing.
        in_valid = 1'b1;
        in_mode  = ARITH_ADD;
        in_clear = 1'b0;
        x = {32'd4, 32'd3, 32'd2, 32'd1};
        y = {32'd40, 32'd30, 32'd20, 32'd10};
        tick();
        in_valid = 1'b0;
        tick();
        chk("lanes_valid", 128'(out_valid), 128'd1);
        chk("lanes_c", c, {32'd44, 32'd33, 32'd22, 32'd11});
        tick();

        // Streaming with a 3-cycle output stall.
        begin
            int sent = 0;
            int got  = 0;
            for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
                out_ready = !(cyc >= 4 && cyc <= 6);
                in_valid  = (sent < 8);
                in_mode   = ARITH_ADD;
                in_clear  = 1'b0;
                for (int l = 0; l < 4; l++) begin
                    x[l*32 +: 32] = 32'(sent * 4 + l);
                    y[l*32 +: 32] = 32'd100;
                end
                #1;
                if (!out_ready) begin
                    chk("stall_in_ready", 128'(in_ready), 128'd0);
                    chk("stall_out_valid", 128'(out_valid), 128'd1);
                end
                if (out_valid) begin
                    logic [127:0] e;
                    for (int l = 0; l < 4; l++) e[l*32 +: 32] = 32'(got * 4 + l + 100);
                    chk($sformatf("stream%0d_c", got), c, e);
                    if (out_ready) got++;
                end
                if (in_valid && in_ready) sent++;
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
            chk("stream_count", 128'(got), 128'd8);
            tick();
            chk("stream_drained", 128'(out_valid), 128'd0);
        end

        // Reset with MAC beats in flight discards them and clears accumulators.
        drive(1'b1, ARITH_MAC, 1'b0, 32'd5, 32'd5);
        tick();
        chk("inflight_valid", 128'(out_valid), 128'd0);
        drive(1'b1, ARITH_MAC, 1'b0, 32'd6, 32'd6);
        reset = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rst2_out_valid", 128'(out_valid), 128'd0);
        chk("rst2_c", c, 128'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_valid", 128'(out_valid), 128'd0);
        end
        drive(1'b1, ARITH_MAC, 1'b0, 32'd1, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_mac_valid", 128'(out_valid), 128'd1);
        chk("post_rst_mac_c", c, {4{32'd1}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
